ascii_dec_parser: RTL and testbench
===================================

Name: ascii_dec_parser

Overview:
- Sequential decoder from puzzle-input ASCII text to binary. It is the inverse of the binary-to-decimal result path.
- Consumes a byte stream of decimal digits and separators. Emits one W-bit binary value per complete number over a valid/ready handshake.
- Sits between the input byte source (RAM reader or UART RX) and the puzzle datapath.

Parameters:
W, 32, width of emitted binary value (>= 4)
NL_CHAR, 8'h0A, byte that marks end of line (sets out_eol)

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  in_data/in_last valid
in_ready  output  1  parser accepts byte this cycle
in_data  input  8  ASCII byte
in_last  input  1  final byte of stream; qualified by in_valid
out_valid  output  1  out_* fields valid
out_ready  input  1  consumer accepts value
out_value  output  W  parsed binary value
out_eol  output  1  number was terminated by NL_CHAR or in_last
out_ovf  output  1  value exceeded W-bit range; out_value holds low W bits

Behaviour:
- Byte handshake: a byte is accepted when in_valid & in_ready. Value handshake: out_valid & out_ready.
- Reset: asynchronous assert, synchronous-safe deassert path. State=IDLE, accumulator=0, ovf/neg flags=0. out_valid=0, out_value=0, out_eol=0, out_ovf=0, in_ready=0 while reset is asserted.
- Reset mid-number or mid-EMIT: the number is dropped and nothing is emitted.
- in_ready = 1 in IDLE and ACCUM; 0 in EMIT.
- Digit: byte in 8'h30..8'h39, d = byte - 8'h30. Every other byte is a separator.
- IDLE:
  - Digit: acc <= d, ovf <= 0, go to ACCUM.
  - Separator: consumed and ignored, no emit. This covers runs of separators and blank lines.
- ACCUM:
  - Digit: acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d in W+4 bits. Low W bits are kept. ovf is sticky-set if the upper 4 bits are nonzero. Stay in ACCUM.
  - Separator: out_value <= acc, out_ovf <= ovf, out_eol <= (byte==NL_CHAR) | in_last. Go to EMIT.
- in_last with a digit, in IDLE or ACCUM: the digit is folded in first, then the same-cycle transition to EMIT with out_eol=1.
- in_last with a separator in IDLE: nothing is emitted.
- EMIT:
  - out_valid=1; out_value, out_eol and out_ovf stay stable until handshake.
  - On handshake: out_valid <= 0, acc <= 0, go to IDLE.
- Latency: terminating byte accepted at cycle N -> out_valid=1 at N+1.
- Throughput: 1 byte/cycle, plus 1 stall cycle per number (the EMIT cycle with out_ready=1).
- Digit count is unlimited. Overflow never stalls or drops; it only sets out_ovf.
- Single driver per register. No combinational path from in_valid or out_ready to in_ready.

Optional Feature:
- Macro ASCII_DEC_PARSER_SIGNED_EN.
- Defined:
  - 8'h2D ('-') in IDLE sets neg and moves to ACCUM with acc=0 and a no-digit flag set.
  - At terminate: out_value <= neg ? -acc : acc (two's complement W bits).
  - out_ovf also sets if the magnitude exceeds 2^(W-1)-1 (positive) or 2^(W-1) (negative).
  - A '-' followed directly by a separator returns to IDLE with no emit.
- Undefined: '-' is an ordinary separator and all values are unsigned.

Test Plan:
- Bytes "123\n", out_ready=1 -> one output at the cycle after '\n': out_value=123, out_eol=1, out_ovf=0. in_ready low exactly 1 cycle.
- "7,42 ,,\n\n" -> exactly two outputs: 7 (eol=0), then 42 (eol=0). The trailing separators and blank line produce nothing.
- W=8, "300," -> out_value=44 (300 mod 256), out_ovf=1. Then "5," -> out_value=5, out_ovf=0 (flag cleared per number).
- "99\n" with out_ready held 0 for 5 cycles after out_valid -> in_ready=0 and out_value=99 stable all 5 cycles. The next byte is accepted the cycle after out_ready=1.
- "8" with in_last=1 on '8' -> out_value=8, out_eol=1, latency 1. Reset pulsed low during "45" (after '4') -> no output, and the next "6\n" yields 6.
- With ASCII_DEC_PARSER_SIGNED_EN, W=32: "-15," -> 32'hFFFFFFF1, and "-," -> no output. Without the macro: "-15," -> out_value=15.

Source files
------------

// File: rtl/ascii_dec_parser_if.sv
// Byte-in / value-out handshake bundle for ascii_dec_parser.
// master = byte source + value consumer side, slave = the parser.
interface ascii_dec_parser_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;
  logic         out_eol;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_eol, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_eol, out_ovf
  );
endinterface

// File: rtl/ascii_dec_parser.sv
// ASCII decimal text to W-bit binary parser, one value per number over valid/ready.
// Optional signed input ('-' prefix, two's complement output): define ASCII_DEC_PARSER_SIGNED_EN.
module ascii_dec_parser #(
  parameter int         W       = 32,
  parameter logic [7:0] NL_CHAR = 8'h0A
) (
  input  logic              clock,
  input  logic              reset,
  ascii_dec_parser_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         run_q;
  logic [W-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] val_q, val_d;
  logic         eol_q, eol_d;
  logic         vovf_q, vovf_d;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
  logic         neg_q, neg_d;
  logic         nodig_q, nodig_d;
`endif

  logic         ready;
  logic         accept;
  logic         is_digit;
  logic [3:0]   digit;
  logic [W+3:0] mac;
  logic         emit;
  logic         term_eol;

  // run_q keeps in_ready low while reset is asserted and for the first edge after release
  assign ready    = run_q & (state_q != S_EMIT);
  assign accept   = bus.in_valid & ready;
  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign digit    = bus.in_data[3:0];
  assign mac      = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                  + {{W{1'b0}}, digit};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    val_d    = val_q;
    eol_d    = eol_q;
    vovf_d   = vovf_q;
    emit     = 1'b0;
    term_eol = 1'b0;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
    neg_d    = neg_q;
    nodig_d  = nodig_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d      = '0;
            acc_d[3:0] = digit;
            ovf_d      = 1'b0;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
            neg_d      = 1'b0;
            nodig_d    = 1'b0;
`endif
            if (bus.in_last) begin
              emit     = 1'b1;
              term_eol = 1'b1;
            end else begin
              state_d  = S_ACCUM;
            end
          end
`ifdef ASCII_DEC_PARSER_SIGNED_EN
          else if ((bus.in_data == 8'h2D) && !bus.in_last) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            neg_d   = 1'b1;
            nodig_d = 1'b1;
            state_d = S_ACCUM;
          end
`endif
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            acc_d = mac[W-1:0];
            ovf_d = ovf_q | (|mac[W+3:W]);
`ifdef ASCII_DEC_PARSER_SIGNED_EN
            nodig_d = 1'b0;
`endif
            if (bus.in_last) begin
              emit     = 1'b1;
              term_eol = 1'b1;
            end
          end
`ifdef ASCII_DEC_PARSER_SIGNED_EN
          else if (nodig_q) begin
            // lone '-' followed by a separator: drop it silently
            state_d = S_IDLE;
            neg_d   = 1'b0;
            nodig_d = 1'b0;
          end
`endif
          else begin
            emit     = 1'b1;
            term_eol = (bus.in_data == NL_CHAR) | bus.in_last;
          end
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
          neg_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Terminate uses the _d values so a digit carrying in_last is folded in first
    if (emit) begin
      state_d = S_EMIT;
      eol_d   = term_eol;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
      val_d   = neg_d ? ('0 - acc_d) : acc_d;
      vovf_d  = ovf_d | (acc_d[W-1] & (~neg_d | (|acc_d[W-2:0])));
`else
      val_d   = acc_d;
      vovf_d  = ovf_d;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      val_q   <= '0;
      eol_q   <= 1'b0;
      vovf_q  <= 1'b0;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
      neg_q   <= 1'b0;
      nodig_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      val_q   <= val_d;
      eol_q   <= eol_d;
      vovf_q  <= vovf_d;
`ifdef ASCII_DEC_PARSER_SIGNED_EN
      neg_q   <= neg_d;
      nodig_q <= nodig_d;
`endif
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_value = val_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_ovf   = vovf_q;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Self-checking bench for ascii_dec_parser: W=32 and W=8 instances fed the same byte stream.
module tb_ascii_dec_parser;

`ifdef ASCII_DEC_PARSER_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif
  localparam logic [7:0] NL = 8'h0A;
  localparam longint unsigned CAP = 64'd1 << 50;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_last   = 1'b0;
  logic       out_ready = 1'b1;
  int unsigned rdy_mode = 0;

  ascii_dec_parser_if #(.W(32)) bus32 ();
  ascii_dec_parser_if #(.W(8))  bus8 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_data   = in_data;
  assign bus32.in_last   = in_last;
  assign bus32.out_ready = out_ready;
  assign bus8.in_valid   = in_valid;
  assign bus8.in_data    = in_data;
  assign bus8.in_last    = in_last;
  assign bus8.out_ready  = out_ready;

  ascii_dec_parser #(.W(32), .NL_CHAR(8'h0A)) u32 (.clock(clock), .reset(reset), .bus(bus32.slave));
  ascii_dec_parser #(.W(8),  .NL_CHAR(8'h0A)) u8  (.clock(clock), .reset(reset), .bus(bus8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [31:0] v;
    logic        o;
    logic        e;
  } rx_t;

  typedef struct packed {
    logic [31:0] v32;
    logic        o32;
    logic [7:0]  v8;
    logic        o8;
    logic        e;
  } exp_t;

  rx_t  rx32[$];
  rx_t  rx8[$];
  exp_t exq[$];
  logic [7:0] sb[$];
  bit         sl[$];

  // Output monitors: capture handshakes, and check fields hold while stalled
  logic        stall32 = 1'b0, stall8 = 1'b0;
  logic [33:0] hold32, hold8;
  always @(negedge clock) begin
    if (!reset) begin
      stall32 = 1'b0;
      stall8  = 1'b0;
    end else begin
      if (stall32) begin
        check("hold32_valid", bus32.out_valid, 1);
        check("hold32_fields", {bus32.out_value, bus32.out_ovf, bus32.out_eol}, hold32);
      end
      if (stall8) begin
        check("hold8_valid", bus8.out_valid, 1);
        check("hold8_fields", {24'd0, bus8.out_value, bus8.out_ovf, bus8.out_eol}, hold8);
      end
      stall32 = bus32.out_valid & ~out_ready;
      stall8  = bus8.out_valid & ~out_ready;
      hold32  = {bus32.out_value, bus32.out_ovf, bus32.out_eol};
      hold8   = {24'd0, bus8.out_value, bus8.out_ovf, bus8.out_eol};
      if (bus32.out_valid && out_ready) rx32.push_back({bus32.out_value, bus32.out_ovf, bus32.out_eol});
      if (bus8.out_valid && out_ready)  rx8.push_back({24'd0, bus8.out_value, bus8.out_ovf, bus8.out_eol});
    end
  end

  always @(posedge clock) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called on a negedge; returns on the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input logic l);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    while (!bus32.in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bus32.in_ready) check("in_ready_timeout", bus32.in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_end && (i == s.len() - 1));
  endtask

  task automatic drain();
    int unsigned t = 0;
    @(negedge clock);
    while ((bus32.out_valid || bus8.out_valid) && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (bus32.out_valid) check("drain_timeout", bus32.out_valid, 0);
    @(negedge clock);
  endtask

  function automatic logic ovf_of(bit neg, longint unsigned mag, int w);
    if (!SIGNED)  return mag >= (64'd1 << w);
    else if (neg) return mag > (64'd1 << (w - 1));
    else          return mag > ((64'd1 << (w - 1)) - 1);
  endfunction

  function automatic void model_emit(bit neg, longint unsigned mag, longint unsigned m32,
                                     longint unsigned m8, bit eol);
    exp_t e;
    e.v32 = neg ? 32'((64'd1 << 32) - m32) : 32'(m32);
    e.v8  = neg ? 8'(256 - m8) : 8'(m8);
    e.o32 = ovf_of(neg, mag, 32);
    e.o8  = ovf_of(neg, mag, 8);
    e.e   = eol;
    exq.push_back(e);
  endfunction

  // Reference: numbers are maximal digit runs, values reduced modulo 2^W
  function automatic void run_model();
    bit innum = 0, has = 0, neg = 0, l;
    longint unsigned mag = 0, m32 = 0, m8 = 0, d;
    logic [7:0] b;
    exq.delete();
    for (int i = 0; i < sb.size(); i++) begin
      b = sb[i];
      l = sl[i];
      if (b >= 8'h30 && b <= 8'h39) begin
        d = longint'(b) - 48;
        if (!innum) begin innum = 1; neg = 0; mag = 0; m32 = 0; m8 = 0; end
        has = 1;
        mag = (mag > CAP / 10) ? CAP : mag * 10 + d;
        m32 = (m32 * 10 + d) % (64'd1 << 32);
        m8  = (m8 * 10 + d) % 256;
        if (l) begin model_emit(neg, mag, m32, m8, 1'b1); innum = 0; end
      end else if (SIGNED && b == 8'h2D && !innum) begin
        if (!l) begin innum = 1; has = 0; neg = 1; mag = 0; m32 = 0; m8 = 0; end
      end else if (innum) begin
        if (has) model_emit(neg, mag, m32, m8, (b == NL) || l);
        innum = 0;
      end
    end
  endfunction

  typedef struct {
    string       s;
    bit          last;
    int          n;
    logic [31:0] v32[2];
    logic [1:0]  o32;
    logic [7:0]  v8[2];
    logic [1:0]  o8;
    logic [1:0]  eol;
  } vec_t;
  vec_t vecs[$];

  // Bit 0 of o32/o8/eol belongs to the first output, bit 1 to the second
  function automatic void add(string s, bit last, int n, logic [31:0] a32, logic [31:0] b32,
                              logic [1:0] o32, logic [7:0] a8, logic [7:0] b8,
                              logic [1:0] o8, logic [1:0] eol);
    vec_t v;
    v.s = s; v.last = last; v.n = n;
    v.v32[0] = a32; v.v32[1] = b32; v.o32 = o32;
    v.v8[0]  = a8;  v.v8[1]  = b8;  v.o8  = o8;
    v.eol = eol;
    vecs.push_back(v);
  endfunction

  initial begin
    int unsigned lowcnt;
    int unsigned r, k;
    int          nc;

    add("123\n",        0, 1, 123, 0, 2'b00, 123, 0, 2'b00, 2'b01);
    add("7,42 ,,\n\n",  0, 2, 7, 42, 2'b00, 7, 42, 2'b00, 2'b00);
    add("300,5,",       0, 2, 300, 5, 2'b00, 44, 5, 2'b01, 2'b00);
    add("8",            1, 1, 8, 0, 2'b00, 8, 0, 2'b00, 2'b01);
    add("12",           1, 1, 12, 0, 2'b00, 12, 0, 2'b00, 2'b01);
    add("5\t9\n",       0, 2, 5, 9, 2'b00, 5, 9, 2'b00, 2'b10);
    add("4294967296\n", 0, 1, 0, 0, 2'b01, 0, 0, 2'b01, 2'b01);
    add("255 256\n",    0, 2, 255, 256, 2'b00, 255, 0, 2'b10, 2'b10);
    add("0009;",        0, 1, 9, 0, 2'b00, 9, 0, 2'b00, 2'b00);
    add("x3y",          1, 1, 3, 0, 2'b00, 3, 0, 2'b00, 2'b01);
    add("\n\n,",        1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
    add("-,",           0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00);
`ifdef ASCII_DEC_PARSER_SIGNED_EN
    add("-15,",         0, 1, 32'hFFFF_FFF1, 0, 2'b00, 8'hF1, 0, 2'b00, 2'b00);
    add("128,",         0, 1, 128, 0, 2'b00, 128, 0, 2'b01, 2'b00);
    add("-128,",        0, 1, 32'hFFFF_FF80, 0, 2'b00, 8'h80, 0, 2'b00, 2'b00);
`else
    add("-15,",         0, 1, 15, 0, 2'b00, 15, 0, 2'b00, 2'b00);
    add("128,",         0, 1, 128, 0, 2'b00, 128, 0, 2'b00, 2'b00);
`endif

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_in_ready",  bus32.in_ready, 0);
    check("rst_out_value", bus32.out_value, 0);
    check("rst_out_eol",   bus32.out_eol, 0);
    check("rst_out_ovf",   bus32.out_ovf, 0);
    check("rst_in_ready8", bus8.in_ready, 0);
    reset = 1'b1;

    // "123\n": latency 1, in_ready low exactly one cycle
    send_str("123", 0);
    send_byte(NL, 0);
    check("lat_out_valid", bus32.out_valid, 1);
    check("lat_value",     bus32.out_value, 123);
    check("lat_eol",       bus32.out_eol, 1);
    check("lat_ovf",       bus32.out_ovf, 0);
    lowcnt = 0;
    while (!bus32.in_ready && lowcnt < 20) begin
      lowcnt++;
      @(negedge clock);
    end
    check("ready_low_cycles", lowcnt, 1);
    check("after_emit_valid", bus32.out_valid, 0);
    drain();

    // "99\n" with consumer stalled for 5 cycles
    rdy_mode  = 2;
    out_ready = 1'b0;
    send_str("99\n", 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus32.out_valid, 1);
      check("stall_ready", bus32.in_ready, 0);
      check("stall_value", bus32.out_value, 99);
      @(negedge clock);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    check("release_ready_still_low", bus32.in_ready, 0);
    @(negedge clock);
    check("release_ready_high", bus32.in_ready, 1);
    check("release_valid_low",  bus32.out_valid, 0);
    rdy_mode = 0;
    drain();

    // Reset pulsed in the middle of "45"
    rx32.delete();
    rx8.delete();
    send_byte("4", 0);
    reset = 1'b0;
    #1;
    check("midrst_valid", bus32.out_valid, 0);
    check("midrst_ready", bus32.in_ready, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    send_str("6\n", 0);
    drain();
    check("midrst_count", rx32.size(), 1);
    if (rx32.size() > 0) check("midrst_value", rx32[0].v, 6);

    // Table vectors
    foreach (vecs[i]) begin
      rx32.delete();
      rx8.delete();
      send_str(vecs[i].s, vecs[i].last);
      drain();
      check($sformatf("v%0d_count32", i), rx32.size(), vecs[i].n);
      check($sformatf("v%0d_count8", i),  rx8.size(),  vecs[i].n);
      for (int j = 0; j < vecs[i].n && j < rx32.size() && j < rx8.size(); j++) begin
        check($sformatf("v%0d_val32_%0d", i, j), rx32[j].v, vecs[i].v32[j]);
        check($sformatf("v%0d_ovf32_%0d", i, j), rx32[j].o, vecs[i].o32[j]);
        check($sformatf("v%0d_eol32_%0d", i, j), rx32[j].e, vecs[i].eol[j]);
        check($sformatf("v%0d_val8_%0d", i, j),  rx8[j].v,  {24'd0, vecs[i].v8[j]});
        check($sformatf("v%0d_ovf8_%0d", i, j),  rx8[j].o,  vecs[i].o8[j]);
        check($sformatf("v%0d_eol8_%0d", i, j),  rx8[j].e,  vecs[i].eol[j]);
      end
    end

    // Random stream against the reference model, random consumer back-pressure
    sb.delete();
    sl.delete();
    while (sb.size() < 400) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        k = $urandom_range(1, (r == 5) ? 14 : 3);
        for (int j = 0; j < k; j++) begin
          sb.push_back(8'(8'h30 + $urandom_range(0, 9)));
          sl.push_back($urandom_range(0, 39) == 0);
        end
      end else begin
        case (r)
          6:       sb.push_back(8'h2C);
          7:       sb.push_back(8'h20);
          8:       sb.push_back(NL);
          default: sb.push_back(($urandom_range(0, 1) != 0) ? 8'h2D : 8'h61);
        endcase
        sl.push_back($urandom_range(0, 39) == 0);
      end
    end
    sb.push_back(NL);
    sl.push_back(1'b0);
    run_model();
    rx32.delete();
    rx8.delete();
    rdy_mode = 1;
    for (int i = 0; i < sb.size(); i++) send_byte(sb[i], sl[i]);
    rdy_mode = 0;
    drain();
    check("rnd_count32", rx32.size(), exq.size());
    check("rnd_count8",  rx8.size(),  exq.size());
    nc = exq.size();
    if (rx32.size() < nc) nc = rx32.size();
    if (rx8.size() < nc)  nc = rx8.size();
    for (int i = 0; i < nc; i++) begin
      check($sformatf("rnd_val32_%0d", i), rx32[i].v, exq[i].v32);
      check($sformatf("rnd_ovf32_%0d", i), rx32[i].o, exq[i].o32);
      check($sformatf("rnd_eol32_%0d", i), rx32[i].e, exq[i].e);
      check($sformatf("rnd_val8_%0d", i),  rx8[i].v,  {24'd0, exq[i].v8});
      check($sformatf("rnd_ovf8_%0d", i),  rx8[i].o,  exq[i].o8);
      check($sformatf("rnd_eol8_%0d", i),  rx8[i].e,  exq[i].e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
